// File: rtl/vai_c0tx_rr_arb.sv
// Round-robin arbiter of NUM_SUB_AFUS sub-AFU requesters onto CCI-P c0 Tx; optional grant stats via VAI_C0TX_ARB_STATS_EN.
// Latency: grant is combinational, registered out_* valid one cycle after the grant.
// Backpressure: c0TxAlmFull high blocks all grants; pointer and outputs hold, out_valid drops.
module vai_c0tx_rr_arb #(
    parameter int NUM_SUB_AFUS = 8,
    // CCI-P c0 Tx request header width (t_if_ccip_c0_Tx minus its valid bit)
    parameter int DATA_WIDTH   = 74
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_SUB_AFUS-1:0]            req_valid,
    input  logic [NUM_SUB_AFUS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_SUB_AFUS-1:0]            req_grant,
    input  logic [NUM_SUB_AFUS-1:0]            sub_afu_reset,
    input  logic                               c0TxAlmFull,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [$clog2(NUM_SUB_AFUS)-1:0]    out_vmid,
    input  logic [$clog2(NUM_SUB_AFUS)-1:0]    stat_sel,
    output logic [31:0]                        stat_data
);

    localparam int IDX_W = $clog2(NUM_SUB_AFUS);

    logic [NUM_SUB_AFUS-1:0] elig;
    logic [NUM_SUB_AFUS-1:0] grant_d;
    logic [IDX_W-1:0]        gnt_idx;
    logic [IDX_W-1:0]        scan_idx;
    logic                    gnt_any;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]        out_vmid_q, out_vmid_d;
    logic [DATA_WIDTH-1:0]   data_arr [NUM_SUB_AFUS];

    for (genvar g = 0; g < NUM_SUB_AFUS; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Reset and almost-full both squash eligibility so no grant can leak out
    assign elig = (reset || c0TxAlmFull) ? '0 : (req_valid & ~sub_afu_reset);

    always_comb begin
        grant_d  = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        // Power-of-two requester count lets the index wrap by truncation
        for (int k = 0; k < NUM_SUB_AFUS; k++) begin
            scan_idx = rr_ptr_q + IDX_W'(k);
            if (!gnt_any && elig[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (gnt_any) begin
            grant_d[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = gnt_any;
        out_data_d  = out_data_q;
        out_vmid_d  = out_vmid_q;
        if (gnt_any) begin
            rr_ptr_d   = gnt_idx + IDX_W'(1);
            out_data_d = data_arr[gnt_idx];
            out_vmid_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_vmid_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_vmid_q  <= out_vmid_d;
        end
    end

    assign req_grant = grant_d;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_vmid  = out_vmid_q;

`ifdef VAI_C0TX_ARB_STATS_EN
    logic [31:0] cnt_q [NUM_SUB_AFUS];
    logic [31:0] stat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                cnt_q[i] <= '0;
            end
            stat_q <= '0;
        end else begin
            // Counters saturate rather than wrap
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                if (grant_d[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
            stat_q <= cnt_q[stat_sel];
        end
    end

    assign stat_data = stat_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_data       = 32'd0;
`endif

endmodule

// File: tb/tb_vai_c0tx_rr_arb.sv
// Directed bench for vai_c0tx_rr_arb: per-cycle expected outputs queued at drive time, checked one cycle later.
module tb_vai_c0tx_rr_arb;
    localparam int N  = 8;
    localparam int DW = 74;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_grant;
    logic [N-1:0]  sub_afu_reset;
    logic          c0TxAlmFull;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_vmid;
    logic [2:0]    stat_sel;
    logic [31:0]   stat_data;

    always #5 clk = ~clk;

    vai_c0tx_rr_arb #(.NUM_SUB_AFUS(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_grant(req_grant), .sub_afu_reset(sub_afu_reset), .c0TxAlmFull(c0TxAlmFull),
        .out_valid(out_valid), .out_data(out_data), .out_vmid(out_vmid),
        .stat_sel(stat_sel), .stat_data(stat_data)
    );

    typedef struct packed {
        logic          v;
        logic [2:0]    vmid;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc_no   = 0;
    logic [2:0]    last_vmid = '0;
    logic [DW-1:0] last_data = '0;

    // Payload changes every cycle so a wrong-cycle capture shows up
    function automatic logic [DW-1:0] pat(input int c, input int i);
        return {34'(c * 7 + 3), 32'(c), 8'(i)};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() >= 2) begin
            mon_e = sb.pop_front();
            chk("out_valid", DW'(out_valid), DW'(mon_e.v));
            chk("out_vmid",  DW'(out_vmid),  DW'(mon_e.vmid));
            chk("out_data",  out_data,       mon_e.data);
        end
    end

    // One arbitration cycle: drive, queue next-cycle outputs, check the grant mid-cycle
    task automatic cyc(input logic [7:0] v, input logic [7:0] sr, input logic af,
                       input logic rst, input logic ev, input int eg);
        exp_t e;
        cyc_no++;
        req_valid     = v;
        sub_afu_reset = sr;
        c0TxAlmFull   = af;
        reset         = rst;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pat(cyc_no, i);
        if (rst) begin
            last_vmid = '0;
            last_data = '0;
        end else if (ev) begin
            last_vmid = 3'(eg);
            last_data = pat(cyc_no, eg);
        end
        e.v    = ev && !rst;
        e.vmid = last_vmid;
        e.data = last_data;
        sb.push_back(e);
        @(negedge clk);
        chk("req_grant", DW'(req_grant), DW'(ev ? 8'(1 << eg) : 8'h00));
`ifndef VAI_C0TX_ARB_STATS_EN
        chk("stat_data_const", DW'(stat_data), '0);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; sub_afu_reset = '0;
        c0TxAlmFull = 1'b0; stat_sel = '0;
        @(posedge clk);
        #1;

        // Reset with every requester active: no grants, outputs cleared
        repeat (2) cyc(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 0);
        chk("reset_stat", DW'(stat_data), '0);

        // Full round robin twice
        for (int k = 0; k < 16; k++) cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, k % 8);

        // Two requesters at the extremes alternate across the wrap
        for (int k = 0; k < 4; k++) cyc(8'h81, 8'h00, 1'b0, 1'b0, 1'b1, (k % 2 == 1) ? 7 : 0);

        // Almost-full stall in cycles 3..6, resume from held pointer
        for (int k = 0; k < 12; k++) begin
            if (k >= 3 && k <= 6) cyc(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 0);
            else                  cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, (k < 3) ? k : k - 4);
        end

        // Lower half masked by sub_afu_reset
        for (int k = 0; k < 4; k++) cyc(8'hFF, 8'h0F, 1'b0, 1'b0, 1'b1, 4 + k);

        // Nothing eligible: outputs hold, pointer holds
        cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 0);

        // Lone requester granted back to back
        for (int k = 0; k < 3; k++) cyc(8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 5);

        // Pointer at 6 but requester 6 masked this very cycle
        cyc(8'hFF, 8'h40, 1'b0, 1'b0, 1'b1, 7);

        // Reset pulse mid-stream, search restarts at 0
        for (int k = 0; k < 3; k++) cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, k);
        cyc(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 0);
        cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        cyc(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1);

`ifdef VAI_C0TX_ARB_STATS_EN
        stat_sel = 3'd3;
        cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 10; k++) cyc(8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 3);
        repeat (2) cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        chk("stat_count10", DW'(stat_data), DW'(32'd10));
        dut.cnt_q[3] = 32'hFFFF_FFFF;
        cyc(8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 3);
        repeat (2) cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        chk("stat_saturate", DW'(stat_data), DW'(32'hFFFF_FFFF));
`endif

        // Drain the last queued expectation
        repeat (2) cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        chk("sb_drained", DW'(sb.size()), DW'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vai_c0tx_rr_arb.md
VAI_C0TX_RR_ARB -- requirements
Module: vai_c0tx_rr_arb

Interface
REQ-001 SHALL have parameter NUM_SUB_AFUS, default 8, number of requesters (power of 2, 2..64).
REQ-002 SHALL have parameter DATA_WIDTH, default $bits(t_if_ccip_c0_Tx)-1, request payload width, valid bit excluded.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_SUB_AFUS  per-requester request pending.
REQ-006 SHALL have port req_data  input  NUM_SUB_AFUS x DATA_WIDTH  per-requester payload.
REQ-007 SHALL have port req_grant  output  NUM_SUB_AFUS  one-hot, combinational; payload consumed in the cycle it is high.
REQ-008 SHALL have port sub_afu_reset  input  NUM_SUB_AFUS  per-requester mask; 1 excludes the requester.
REQ-009 SHALL have port c0TxAlmFull  input  1  downstream almost-full.
REQ-010 SHALL have port out_valid  output  1  registered request valid toward CCI-P c0 Tx.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  registered granted payload.
REQ-012 SHALL have port out_vmid  output  $clog2(NUM_SUB_AFUS)  registered index of the granted requester.
REQ-013 SHALL have port stat_sel  input  $clog2(NUM_SUB_AFUS)  statistics counter select.
REQ-014 SHALL have port stat_data  output  32  selected grant count, registered.

Function
REQ-015 Eligible requester i SHALL satisfy req_valid[i] && !sub_afu_reset[i].
REQ-016 When c0TxAlmFull==0 and any requester is eligible, exactly one grant SHALL assert per cycle.
REQ-017 Selection SHALL be round-robin: the first eligible index at or after rr_ptr, wrapping from NUM_SUB_AFUS-1 to 0.
REQ-018 After granting index g, rr_ptr SHALL become (g+1) mod NUM_SUB_AFUS; with no grant, rr_ptr SHALL hold.
REQ-019 When c0TxAlmFull==1, req_grant SHALL be all zero and out_valid SHALL be 0 in the next cycle.
REQ-020 Latency SHALL be 1 cycle: a grant at cycle N gives out_valid=1, out_data=req_data[g], out_vmid=g at cycle N+1.
REQ-021 With no grant at cycle N, out_valid SHALL be 0 at N+1; out_data and out_vmid SHALL hold.
REQ-022 Sustained throughput SHALL be one request per cycle; N eligible requesters SHALL each be served once in any N consecutive granting cycles.
REQ-023 An assertion of sub_afu_reset[i] SHALL take effect in the same cycle (no grant to i); in-flight out_* SHALL NOT be cancelled.
REQ-024 A single eligible requester SHALL be granted every cycle while c0TxAlmFull==0.

Reset
REQ-025 On reset: out_valid=0, out_data=0, out_vmid=0, rr_ptr=0, stat_data=0, all grant counters=0.
REQ-026 req_grant SHALL be all zero while reset==1, regardless of inputs.
REQ-027 Reset asserted mid-stream SHALL drop any registered output; the first grant after release SHALL start the search at index 0.

Configuration
REQ-028 Macro VAI_C0TX_ARB_STATS_EN SHALL gate the statistics feature.
REQ-029 With the macro defined, each requester SHALL have a 32-bit grant counter, +1 per grant, saturating at 32'hFFFFFFFF; stat_data SHALL show counter[stat_sel] one cycle later.
REQ-030 Without the macro, no counters SHALL be built and stat_data SHALL be constant 0.

Verification
REQ-031 Reset, then all 8 req_valid=1, c0TxAlmFull=0 for 16 cycles -> out_vmid sequence 0,1,...,7,0,...,7 starting 1 cycle after the first grant.
REQ-032 req_valid=8'b1000_0001 continuously -> grants alternate 0,7,0,7; index 7 is followed by wrap to 0.
REQ-033 All 8 requesting, c0TxAlmFull=1 for cycles 3-6 -> no grants in 3-6, out_valid=0 in 4-7, arbitration resumes at the held rr_ptr.
REQ-034 req_valid=8'hFF, sub_afu_reset=8'h0F -> only indices 4-7 granted, in order 4,5,6,7.
REQ-035 Reset pulsed while streaming -> next cycle out_valid=0; first post-reset grant goes to index 0.
REQ-036 With VAI_C0TX_ARB_STATS_EN, 10 grants to index 3, stat_sel=3 -> stat_data=10; counter preloaded to 32'hFFFFFFFF stays 32'hFFFFFFFF after a further grant.
